// File: rtl/jtag_tap.sv
// Oversampled IEEE 1149.1 TAP controller in the clk domain.
// TCK is synchronized and edge-detected; IR plus IDCODE/BYPASS/USER DRs.
module jtag_tap #(
  parameter int          IR_LEN       = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'h1DEAD3FF,
  parameter int          USER_LEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                jtag_clk,
  input  logic                jtag_tms,
  input  logic                jtag_tdi,
  input  logic                jtag_rst_n,
  output logic                jtag_tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_LEN-1:0]   ir_value,
  input  logic [USER_LEN-1:0] user_capture_data,
  output logic [USER_LEN-1:0] user_update_data,
  output logic                user_update_valid
);

  typedef enum logic [3:0] {
    TLR   = 4'hF,
    RTI   = 4'hC,
    SELDR = 4'h7,
    CAPDR = 4'h6,
    SHDR  = 4'h2,
    EX1DR = 4'h1,
    PAUDR = 4'h3,
    EX2DR = 4'h0,
    UPDDR = 4'h5,
    SELIR = 4'h4,
    CAPIR = 4'hE,
    SHIR  = 4'hA,
    EX1IR = 4'h9,
    PAUIR = 4'hB,
    EX2IR = 4'h8,
    UPDIR = 4'hD
  } tap_e;

  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(5'h01);
  localparam logic [IR_LEN-1:0] IR_USER   = IR_LEN'(5'h10);

  logic r_tck_s1, r_tck_s2, r_tck_s3;
  logic r_tms_s1, r_tms_s2;
  logic r_tdi_s1, r_tdi_s2;
  logic r_trst_s1, r_trst_s2;

  logic w_rise, w_fall, w_trst, w_act;
  logic w_tms, w_tdi;

  tap_e r_state, w_next;

  logic w_in_shdr, w_in_shir, w_in_capdr;
  logic w_in_capir, w_in_updir, w_in_upddr;
  logic w_in_tlr;

  logic [IR_LEN-1:0]   r_ir_sr;
  logic [IR_LEN-1:0]   r_ir;
  logic [31:0]         r_id_sr;
  logic [USER_LEN-1:0] r_user_sr;
  logic                r_byp_sr;
  logic                r_tdo, r_tdo_en;
  logic [USER_LEN-1:0] r_upd_data;
  logic                r_upd_valid;

  logic w_sel_id, w_sel_user, w_sel_byp;
  logic w_dr_lsb;

  // Two-flop synchronizers plus an extra TCK stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tck_s1  <= 1'b0;
      r_tck_s2  <= 1'b0;
      r_tck_s3  <= 1'b0;
      r_tms_s1  <= 1'b0;
      r_tms_s2  <= 1'b0;
      r_tdi_s1  <= 1'b0;
      r_tdi_s2  <= 1'b0;
      r_trst_s1 <= 1'b1;
      r_trst_s2 <= 1'b1;
    end else begin
      r_tck_s1  <= jtag_clk;
      r_tck_s2  <= r_tck_s1;
      r_tck_s3  <= r_tck_s2;
      r_tms_s1  <= jtag_tms;
      r_tms_s2  <= r_tms_s1;
      r_tdi_s1  <= jtag_tdi;
      r_tdi_s2  <= r_tdi_s1;
      r_trst_s1 <= jtag_rst_n;
      r_trst_s2 <= r_trst_s1;
    end
  end

  assign w_rise = r_tck_s2 & ~r_tck_s3;
  assign w_fall = ~r_tck_s2 & r_tck_s3;
  assign w_trst = ~r_trst_s2;
  assign w_act  = w_rise & ~w_trst;
  assign w_tms  = r_tms_s2;
  assign w_tdi  = r_tdi_s2;

  // TAP state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TLR;
    else        r_state <= w_next;
  end

  // Standard 1149.1 next-state table, advanced on TCK rise
  always_comb begin
    w_next = r_state;
    if (w_trst) begin
      w_next = TLR;
    end else if (w_rise) begin
      case (r_state)
        TLR:     w_next = w_tms ? TLR   : RTI;
        RTI:     w_next = w_tms ? SELDR : RTI;
        SELDR:   w_next = w_tms ? SELIR : CAPDR;
        CAPDR:   w_next = w_tms ? EX1DR : SHDR;
        SHDR:    w_next = w_tms ? EX1DR : SHDR;
        EX1DR:   w_next = w_tms ? UPDDR : PAUDR;
        PAUDR:   w_next = w_tms ? EX2DR : PAUDR;
        EX2DR:   w_next = w_tms ? UPDDR : SHDR;
        UPDDR:   w_next = w_tms ? SELDR : RTI;
        SELIR:   w_next = w_tms ? TLR   : CAPIR;
        CAPIR:   w_next = w_tms ? EX1IR : SHIR;
        SHIR:    w_next = w_tms ? EX1IR : SHIR;
        EX1IR:   w_next = w_tms ? UPDIR : PAUIR;
        PAUIR:   w_next = w_tms ? EX2IR : PAUIR;
        EX2IR:   w_next = w_tms ? UPDIR : SHIR;
        UPDIR:   w_next = w_tms ? SELDR : RTI;
        default: w_next = TLR;
      endcase
    end
  end

  // State decode flags
  always_comb begin
    tap_state  = r_state;
    w_in_tlr   = (r_state == TLR);
    w_in_shdr  = (r_state == SHDR);
    w_in_shir  = (r_state == SHIR);
    w_in_capdr = (r_state == CAPDR);
    w_in_capir = (r_state == CAPIR);
    w_in_upddr = (r_state == UPDDR);
    w_in_updir = (r_state == UPDIR);
  end

  assign w_sel_id   = (r_ir == IR_IDCODE);
  assign w_sel_user = (r_ir == IR_USER);
  assign w_sel_byp  = ~w_sel_id & ~w_sel_user;

  // Instruction shift register: capture 0..01, shift right from TDI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_sr <= '0;
    end else if (w_act) begin
      if (w_in_capir)
        r_ir_sr <= IR_LEN'(1);
      else if (w_in_shir)
        r_ir_sr <= {w_tdi, r_ir_sr[IR_LEN-1:1]};
    end
  end

  // Instruction register: forced to IDCODE in TLR or on TRST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ir <= IR_IDCODE;
    else if (w_trst || w_in_tlr)
      r_ir <= IR_IDCODE;
    else if (w_act && w_in_updir)
      r_ir <= r_ir_sr;
  end

  // Data registers: capture and shift only the selected one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_sr   <= '0;
      r_user_sr <= '0;
      r_byp_sr  <= 1'b0;
    end else if (w_act && w_in_capdr) begin
      unique case (1'b1)
        w_sel_id:   r_id_sr   <= IDCODE_VALUE;
        w_sel_user: r_user_sr <= user_capture_data;
        w_sel_byp:  r_byp_sr  <= 1'b0;
        default: ;
      endcase
    end else if (w_act && w_in_shdr) begin
      unique case (1'b1)
        w_sel_id:   r_id_sr   <= {w_tdi, r_id_sr[31:1]};
        w_sel_user: r_user_sr <= {w_tdi, r_user_sr[USER_LEN-1:1]};
        w_sel_byp:  r_byp_sr  <= w_tdi;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dr_lsb = r_byp_sr;
    unique case (1'b1)
      w_sel_id:   w_dr_lsb = r_id_sr[0];
      w_sel_user: w_dr_lsb = r_user_sr[0];
      default: ;
    endcase
  end

  // TDO launched on TCK fall so it is stable across the next rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_fall) begin
      if (w_in_shdr) begin
        r_tdo    <= w_dr_lsb;
        r_tdo_en <= 1'b1;
      end else if (w_in_shir) begin
        r_tdo    <= r_ir_sr[0];
        r_tdo_en <= 1'b1;
      end else begin
        r_tdo    <= 1'b0;
        r_tdo_en <= 1'b0;
      end
    end
  end

  // USER update latch with a single-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_data  <= '0;
      r_upd_valid <= 1'b0;
    end else begin
      r_upd_valid <= 1'b0;
      if (w_act && w_in_upddr && w_sel_user) begin
        r_upd_data  <= r_user_sr;
        r_upd_valid <= 1'b1;
      end
    end
  end

  assign ir_value          = r_ir;
  assign jtag_tdo          = r_tdo;
  assign tdo_en            = r_tdo_en;
  assign user_update_data  = r_upd_data;
  assign user_update_valid = r_upd_valid;

endmodule

// File: tb/tb_jtag_tap.sv
// Bench for jtag_tap: directed TAP scans with queued expectations.
// Monitors pop TDO bits and USER update words as the DUT presents them.
module tb_jtag_tap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jtag_clk = 1'b0;
  logic        jtag_tms = 1'b0;
  logic        jtag_tdi = 1'b0;
  logic        jtag_rst_n = 1'b1;
  logic        jtag_tdo;
  logic        tdo_en;
  logic [3:0]  tap_state;
  logic [4:0]  ir_value;
  logic [31:0] user_capture_data = '0;
  logic [31:0] user_update_data;
  logic        user_update_valid;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  logic        q_tdo[$];
  logic [31:0] q_upd[$];

  jtag_tap dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .jtag_clk          (jtag_clk),
    .jtag_tms          (jtag_tms),
    .jtag_tdi          (jtag_tdi),
    .jtag_rst_n        (jtag_rst_n),
    .jtag_tdo          (jtag_tdo),
    .tdo_en            (tdo_en),
    .tap_state         (tap_state),
    .ir_value          (ir_value),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update_valid (user_update_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // TDO monitor: each TCK rise with tdo_en high carries one bit
  always @(posedge jtag_clk) begin
    if (tdo_en === 1'b1) begin
      if (q_tdo.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tdo_extra: got %b want none", jtag_tdo);
      end else begin
        logic e;
        e = q_tdo.pop_front();
        chk("tdo", {31'd0, jtag_tdo}, {31'd0, e});
      end
    end
  end

  // Update monitor: every valid cycle must match a queued word
  always @(negedge clk) begin
    if (user_update_valid === 1'b1) begin
      n_pulse++;
      if (q_upd.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL upd_extra: got %h want none", user_update_data);
      end else begin
        logic [31:0] e;
        e = q_upd.pop_front();
        chk("upd_data", user_update_data, e);
      end
    end
  end

  // One TCK period of 16 clk: 8 low (TMS/TDI set), 8 high
  task automatic tck(input logic tms, input logic tdi);
    @(negedge clk);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (4) @(negedge clk);
    jtag_clk = 1'b1;
    repeat (8) @(negedge clk);
    jtag_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // DR scan from RTI back to RTI
  task automatic dr_scan(input int n, input logic [31:0] din,
                         input logic [31:0] dexp);
    logic [31:0] x;
    x = dexp;
    for (int i = 0; i < n; i++) q_tdo.push_back(x[i]);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tck(i == n - 1, din[i]);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // IR scan from RTI back to RTI; capture shifts out 1,0,0,0,0
  task automatic ir_scan(input logic [4:0] din);
    q_tdo.push_back(1'b1);
    for (int i = 1; i < 5; i++) q_tdo.push_back(1'b0);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck(i == 4, din[i]);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] cap;
    repeat (4) @(negedge clk);
    chk("rst_state", {28'd0, tap_state}, 32'hF);
    chk("rst_ir", {27'd0, ir_value}, 32'h01);
    chk("rst_tdo", {31'd0, jtag_tdo}, 32'd0);
    chk("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
    chk("rst_valid", {31'd0, user_update_valid}, 32'd0);
    chk("rst_upd_data", user_update_data, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tck(1'b0, 1'b0);
    chk("seq_rti", {28'd0, tap_state}, 32'hC);
    tck(1'b1, 1'b0);
    chk("seq_seldr", {28'd0, tap_state}, 32'h7);
    tck(1'b0, 1'b0);
    chk("seq_capdr", {28'd0, tap_state}, 32'h6);
    tck(1'b0, 1'b0);
    chk("seq_shdr", {28'd0, tap_state}, 32'h2);
    chk("seq_tdo_en", {31'd0, tdo_en}, 32'd1);
    q_tdo.push_back(1'b1);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    chk("seq_tlr", {28'd0, tap_state}, 32'hF);
    chk("seq_tdo_en_off", {31'd0, tdo_en}, 32'd0);

    tck(1'b0, 1'b0);
    dr_scan(32, 32'd0, 32'h1DEAD3FF);
    chk("idc_state", {28'd0, tap_state}, 32'hC);
    chk("idc_ir", {27'd0, ir_value}, 32'h01);

    ir_scan(5'h1F);
    chk("byp_ir", {27'd0, ir_value}, 32'h1F);
    dr_scan(4, 32'b1101, 32'b1010);

    ir_scan(5'h10);
    chk("usr_ir", {27'd0, ir_value}, 32'h10);
    user_capture_data = 32'hA5A5_0F0F;
    q_upd.push_back(32'h1234_5678);
    dr_scan(32, 32'h1234_5678, 32'hA5A5_0F0F);
    chk("usr_upd_data", user_update_data, 32'h1234_5678);
    chk("usr_pulses", n_pulse, 32'd1);

    user_capture_data = 32'hA5A5_0F0F;
    cap = 32'hA5A5_0F0F;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) q_tdo.push_back(cap[i]);
    for (int i = 0; i < 10; i++) tck(1'b0, 1'b1);
    chk("trst_pre_state", {28'd0, tap_state}, 32'h2);
    chk("trst_pre_en", {31'd0, tdo_en}, 32'd1);
    @(negedge clk);
    jtag_rst_n = 1'b0;
    repeat (5) @(negedge clk);
    jtag_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("trst_state", {28'd0, tap_state}, 32'hF);
    chk("trst_ir", {27'd0, ir_value}, 32'h01);
    chk("trst_tdo_en", {31'd0, tdo_en}, 32'd0);
    chk("trst_tdo", {31'd0, jtag_tdo}, 32'd0);
    chk("trst_upd_data", user_update_data, 32'h1234_5678);
    tck(1'b0, 1'b0);
    chk("post_rti", {28'd0, tap_state}, 32'hC);

    repeat (4) @(negedge clk);
    chk("tdo_q_empty", q_tdo.size(), 32'd0);
    chk("upd_q_empty", q_upd.size(), 32'd0);
    chk("pulse_total", n_pulse, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
